// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared encodings and helpers for the pipeline hazard logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_WB     = 2'b01;
    localparam logic [1:0] FWD_MEM    = 2'b10;
    localparam logic [1:0] DM2REG_MEM = 2'b01;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // $zero is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] wa_m,
        input logic       we_m,
        input logic [4:0] wa_w,
        input logic       we_w
    );
        if (we_m && reg_match(src, wa_m)) begin
            return FWD_MEM;
        end
        if (we_w && reg_match(src, wa_w)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_seq.sv
`default_nettype none
// ============================================================================
//  Module      : md_seq
//  Description : Multiply/divide occupancy sequencer and HI/LO commit strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_seq
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic div,
    output logic busy,
    output logic done
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [0:0]       ST_IDLE  = IDLE;
    localparam logic [0:0]       ST_BUSY  = BUSY;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    // A start seen while BUSY is dropped; the decode stall keeps it from happening.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_state <= ST_BUSY;
                r_cnt   <= div ? DIV_LOAD : MUL_LOAD;
            end
        end else begin
            if (r_cnt == '0) begin
                r_state <= ST_IDLE;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign busy = (r_state == ST_BUSY);
    assign done = busy && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Forwarding, stall/flush and mult/div sequencing for the pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        branch_d,
    input  logic        jr_d,
    input  logic        md_op_d,
    input  logic        hilo_read_d,
    input  logic [4:0]  rs_e,
    input  logic [4:0]  rt_e,
    input  logic [4:0]  rf_wa_e,
    input  logic        we_reg_e,
    input  logic [1:0]  dm2reg_e,
    input  logic        md_start_e,
    input  logic        md_div_e,
    input  logic [4:0]  rf_wa_m,
    input  logic        we_reg_m,
    input  logic [1:0]  dm2reg_m,
    input  logic [4:0]  rf_wa_w,
    input  logic        we_reg_w,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_e,
    output logic        forward_ad,
    output logic        forward_bd,
    output logic [1:0]  forward_ae,
    output logic [1:0]  forward_be,
    output logic        md_busy,
    output logic        hilo_we,
    output logic [15:0] stall_cnt
);

    logic        w_load_e;
    logic        w_load_m;
    logic        w_rs_used;
    logic        w_lw_stall;
    logic        w_br_stall;
    logic        w_md_stall;
    logic        w_stall;
    logic [15:0] r_stall_cnt;

    md_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_seq (
        .clk   (clk),
        .rst   (rst),
        .start (md_start_e),
        .div   (md_div_e),
        .busy  (md_busy),
        .done  (hilo_we)
    );

    assign w_load_e  = (dm2reg_e == DM2REG_MEM);
    assign w_load_m  = (dm2reg_m == DM2REG_MEM);
    assign w_rs_used = branch_d || jr_d;

    assign w_lw_stall = w_load_e && (reg_match(rf_wa_e, rs_d) || reg_match(rf_wa_e, rt_d));

    // Decode compares can only take alu_outm, so an E producer or an M load must wait.
    assign w_br_stall =
        (w_rs_used && ((we_reg_e && reg_match(rf_wa_e, rs_d)) ||
                       (w_load_m && reg_match(rf_wa_m, rs_d)))) ||
        (branch_d  && ((we_reg_e && reg_match(rf_wa_e, rt_d)) ||
                       (w_load_m && reg_match(rf_wa_m, rt_d))));

    assign w_md_stall = (md_op_d || hilo_read_d) && (md_busy || md_start_e);

    assign w_stall = !rst && (w_lw_stall || w_br_stall || w_md_stall);

    assign stall_f = w_stall;
    assign stall_d = w_stall;
    assign flush_e = w_stall;

    assign forward_ad = !rst && we_reg_m && !w_load_m && reg_match(rs_d, rf_wa_m);
    assign forward_bd = !rst && we_reg_m && !w_load_m && reg_match(rt_d, rf_wa_m);

    assign forward_ae = rst ? FWD_RF : fwd_sel(rs_e, rf_wa_m, we_reg_m, rf_wa_w, we_reg_w);
    assign forward_be = rst ? FWD_RF : fwd_sel(rt_e, rf_wa_m, we_reg_m, rf_wa_w, we_reg_w);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
